// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: FSM state encoding, port IDs, timer width.
package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_BUSY = 2'd1,
    ARB_RESP = 2'd2
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  // Wide enough for the largest legal TIMEOUT (255).
  localparam int TIMER_W = 8;

endpackage

// File: rtl/rr_pick.sv
// Two-port round-robin pick: on a tie the port that did not win the last tie is chosen.
module rr_pick
  import mem_port_arbiter_pkg::*;
(
  input  logic req0,
  input  logic req1,
  input  logic last_grant,
  output logic grant_valid,
  output logic grant_id
);

  assign grant_valid = req0 | req1;

  always_comb begin
    grant_id = PORT_CPU;
    if (req0 && req1) begin
      grant_id = ~last_grant;
    end else if (req1) begin
      grant_id = PORT_DBG;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the unified memory port between the CPU (port 0) and debug loader (port 1),
// latching each request at grant and aborting accesses that wait too long.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_err,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_err,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [TIMER_W-1:0] TIMER_LAST = TIMER_W'(TIMEOUT - 1);

  arb_state_t         r_state;
  logic               r_last_grant;
  logic               r_grant_id;
  logic [TIMER_W-1:0] r_timer;
  logic               r_mem_valid;
  logic               r_mem_we;
  logic [ADDR_W-1:0]  r_mem_addr;
  logic [DATA_W-1:0]  r_mem_wdata;
  logic               r_cpu_ack;
  logic               r_cpu_err;
  logic [DATA_W-1:0]  r_cpu_rdata;
  logic               r_dbg_ack;
  logic               r_dbg_err;
  logic [DATA_W-1:0]  r_dbg_rdata;

  logic               w_grant_valid;
  logic               w_grant_id;
  logic               w_sel_we;
  logic [ADDR_W-1:0]  w_sel_addr;
  logic [DATA_W-1:0]  w_sel_wdata;

  rr_pick u_rr_pick (
    .req0        (cpu_req),
    .req1        (dbg_req),
    .last_grant  (r_last_grant),
    .grant_valid (w_grant_valid),
    .grant_id    (w_grant_id)
  );

  assign w_sel_we    = (w_grant_id == PORT_DBG) ? dbg_we    : cpu_we;
  assign w_sel_addr  = (w_grant_id == PORT_DBG) ? dbg_addr  : cpu_addr;
  assign w_sel_wdata = (w_grant_id == PORT_DBG) ? dbg_wdata : cpu_wdata;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ARB_IDLE;
      r_last_grant <= PORT_DBG;
      r_grant_id   <= PORT_CPU;
      r_timer      <= '0;
      r_mem_valid  <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_ack    <= 1'b0;
      r_cpu_err    <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dbg_ack    <= 1'b0;
      r_dbg_err    <= 1'b0;
      r_dbg_rdata  <= '0;
    end else begin
      r_cpu_ack <= 1'b0;
      r_dbg_ack <= 1'b0;
      case (r_state)
        ARB_IDLE: begin
          if (w_grant_valid) begin
            // Only a tie moves the round-robin pointer.
            if (cpu_req && dbg_req) begin
              r_last_grant <= w_grant_id;
            end
            r_grant_id  <= w_grant_id;
            r_mem_we    <= w_sel_we;
            r_mem_addr  <= w_sel_addr;
            r_mem_wdata <= w_sel_wdata;
            r_mem_valid <= 1'b1;
            r_timer     <= '0;
            r_state     <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (mem_ready) begin
            if (r_grant_id == PORT_CPU) begin
              if (!r_mem_we) r_cpu_rdata <= mem_rdata;
              r_cpu_err <= 1'b0;
              r_cpu_ack <= 1'b1;
            end else begin
              if (!r_mem_we) r_dbg_rdata <= mem_rdata;
              r_dbg_err <= 1'b0;
              r_dbg_ack <= 1'b1;
            end
            r_mem_valid <= 1'b0;
            r_state     <= ARB_RESP;
          end else if (r_timer == TIMER_LAST) begin
            if (r_grant_id == PORT_CPU) begin
              r_cpu_rdata <= '0;
              r_cpu_err   <= 1'b1;
              r_cpu_ack   <= 1'b1;
            end else begin
              r_dbg_rdata <= '0;
              r_dbg_err   <= 1'b1;
              r_dbg_ack   <= 1'b1;
            end
            r_mem_valid <= 1'b0;
            r_state     <= ARB_RESP;
          end else begin
            r_timer <= r_timer + TIMER_W'(1);
          end
        end
        ARB_RESP: r_state <= ARB_IDLE;
        default:  r_state <= ARB_IDLE;
      endcase
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign cpu_ack   = r_cpu_ack;
  assign cpu_err   = r_cpu_err;
  assign cpu_rdata = r_cpu_rdata;
  assign dbg_ack   = r_dbg_ack;
  assign dbg_err   = r_dbg_err;
  assign dbg_rdata = r_dbg_rdata;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table, directed corner sequences,
// and randomized two-requester traffic against a transaction-level reference.
module tb_mem_port_arbiter;

  localparam int T_MAIN = 8;
  localparam int T_SHORT = 4;
  localparam int PH_IDLE = 0;
  localparam int PH_BUSY = 1;
  localparam int PH_RESP = 2;

  logic        clk, reset;
  logic        cpu_req, cpu_we, dbg_req, dbg_we, mem_ready;
  logic [31:0] cpu_addr, cpu_wdata, dbg_addr, dbg_wdata, mem_rdata;

  logic        cpu_ack, cpu_err, dbg_ack, dbg_err, mem_valid, mem_we;
  logic [31:0] cpu_rdata, dbg_rdata, mem_addr, mem_wdata;

  logic        t4_cpu_ack, t4_cpu_err, t4_dbg_ack, t4_dbg_err, t4_mem_valid, t4_mem_we;
  logic [31:0] t4_cpu_rdata, t4_dbg_rdata, t4_mem_addr, t4_mem_wdata;

  int n_checks = 0;
  int n_errors = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T_MAIN)) u_dut (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(cpu_ack), .cpu_err(cpu_err), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(dbg_ack), .dbg_err(dbg_err), .dbg_rdata(dbg_rdata),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(T_SHORT)) u_dut_t4 (
    .clk(clk), .reset(reset),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_ack(t4_cpu_ack), .cpu_err(t4_cpu_err), .cpu_rdata(t4_cpu_rdata),
    .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
    .dbg_ack(t4_dbg_ack), .dbg_err(t4_dbg_err), .dbg_rdata(t4_dbg_rdata),
    .mem_valid(t4_mem_valid), .mem_we(t4_mem_we), .mem_addr(t4_mem_addr),
    .mem_wdata(t4_mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    mem_ready = 1'b0;
    tick();
    tick();
    reset = 1'b0;
  endtask

  typedef struct {
    bit          rst, creq, dreq, rdy;
    logic [31:0] mrd;
    bit          e_mv;
    logic [31:0] e_maddr;
    bit          e_cack, e_dack;
    logic [31:0] e_crd, e_drd;
  } vec_t;

  vec_t tbl[22];

  typedef struct {
    bit          active;
    bit          we;
    logic [31:0] addr, wdata;
    int          gap;
    logic [31:0] exp_rd;
    bit          exp_err;
  } req_t;

  req_t        rq[2];
  logic [31:0] mem_m[16];
  int          phase, nphase, cur, bidx, wait_n, last_tie;
  bit          r0, r1;

  initial begin
    reset = 1'b1;
    cpu_req = 0; cpu_we = 0; cpu_addr = 0; cpu_wdata = 0;
    dbg_req = 0; dbg_we = 0; dbg_addr = 0; dbg_wdata = 0;
    mem_ready = 0; mem_rdata = 0;

    //          rst creq dreq rdy mrd            mv maddr        cack dack crd           drd
    tbl[0]  = '{0, 1, 0, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,        32'h0};
    tbl[1]  = '{0, 1, 0, 1, 32'hDEADBEEF,  1, 32'h100, 0, 0, 32'h0,        32'h0};
    tbl[2]  = '{0, 0, 0, 0, 32'h0,         0, 32'h100, 1, 0, 32'hDEADBEEF, 32'h0};
    tbl[3]  = '{0, 0, 0, 1, 32'hBAD0BAD0,  0, 32'h100, 0, 0, 32'hDEADBEEF, 32'h0};
    tbl[4]  = '{1, 0, 0, 0, 32'h0,         0, 32'h100, 0, 0, 32'hDEADBEEF, 32'h0};
    tbl[5]  = '{0, 1, 1, 0, 32'h0,         0, 32'h0,   0, 0, 32'h0,        32'h0};
    tbl[6]  = '{0, 1, 1, 1, 32'h11111111,  1, 32'h100, 0, 0, 32'h0,        32'h0};
    tbl[7]  = '{0, 0, 1, 0, 32'h0,         0, 32'h100, 1, 0, 32'h11111111, 32'h0};
    tbl[8]  = '{0, 0, 1, 0, 32'h0,         0, 32'h100, 0, 0, 32'h11111111, 32'h0};
    tbl[9]  = '{0, 0, 1, 1, 32'h22222222,  1, 32'h200, 0, 0, 32'h11111111, 32'h0};
    tbl[10] = '{0, 0, 0, 0, 32'h0,         0, 32'h200, 0, 1, 32'h11111111, 32'h22222222};
    tbl[11] = '{0, 1, 1, 0, 32'h0,         0, 32'h200, 0, 0, 32'h11111111, 32'h22222222};
    tbl[12] = '{0, 1, 1, 1, 32'h33333333,  1, 32'h200, 0, 0, 32'h11111111, 32'h22222222};
    tbl[13] = '{0, 1, 0, 0, 32'h0,         0, 32'h200, 0, 1, 32'h11111111, 32'h33333333};
    tbl[14] = '{0, 1, 0, 0, 32'h0,         0, 32'h200, 0, 0, 32'h11111111, 32'h33333333};
    tbl[15] = '{0, 1, 0, 1, 32'h44444444,  1, 32'h100, 0, 0, 32'h11111111, 32'h33333333};
    tbl[16] = '{0, 1, 0, 0, 32'h0,         0, 32'h100, 1, 0, 32'h44444444, 32'h33333333};
    tbl[17] = '{0, 1, 0, 0, 32'h0,         0, 32'h100, 0, 0, 32'h44444444, 32'h33333333};
    tbl[18] = '{0, 1, 0, 1, 32'h55555555,  1, 32'h100, 0, 0, 32'h44444444, 32'h33333333};
    tbl[19] = '{0, 0, 0, 0, 32'h0,         0, 32'h100, 1, 0, 32'h55555555, 32'h33333333};
    tbl[20] = '{0, 0, 0, 0, 32'h0,         0, 32'h100, 0, 0, 32'h55555555, 32'h33333333};
    tbl[21] = '{0, 0, 0, 0, 32'h0,         0, 32'h100, 0, 0, 32'h55555555, 32'h33333333};

    // Vector table: zero-wait read, tie ordering, held request.
    cpu_addr = 32'h100; cpu_wdata = 32'hC0C00001;
    dbg_addr = 32'h200; dbg_wdata = 32'hD0D00002;
    do_reset();
    for (int i = 0; i < 22; i++) begin
      check($sformatf("tbl%0d mem_valid", i), mem_valid, tbl[i].e_mv);
      check($sformatf("tbl%0d mem_addr", i), mem_addr, tbl[i].e_maddr);
      check($sformatf("tbl%0d mem_we", i), mem_we, 0);
      check($sformatf("tbl%0d cpu_ack", i), cpu_ack, tbl[i].e_cack);
      check($sformatf("tbl%0d dbg_ack", i), dbg_ack, tbl[i].e_dack);
      check($sformatf("tbl%0d cpu_rdata", i), cpu_rdata, tbl[i].e_crd);
      check($sformatf("tbl%0d dbg_rdata", i), dbg_rdata, tbl[i].e_drd);
      check($sformatf("tbl%0d cpu_err", i), cpu_err, 0);
      check($sformatf("tbl%0d dbg_err", i), dbg_err, 0);
      reset = tbl[i].rst;
      cpu_req = tbl[i].creq;
      dbg_req = tbl[i].dreq;
      mem_ready = tbl[i].rdy;
      mem_rdata = tbl[i].mrd;
      tick();
    end

    // DBG write with five wait states; requester inputs wander while BUSY.
    dbg_we = 1'b1; dbg_addr = 32'h40; dbg_wdata = 32'h12345678; dbg_req = 1'b1;
    mem_ready = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      check("wr mem_valid", mem_valid, 1);
      check("wr mem_we", mem_we, 1);
      check("wr mem_addr", mem_addr, 32'h40);
      check("wr mem_wdata", mem_wdata, 32'h12345678);
      check("wr dbg_ack early", dbg_ack, 0);
      dbg_addr = $urandom; dbg_wdata = $urandom; dbg_we = 1'($urandom_range(0, 1));
      mem_ready = (i == 5);
      mem_rdata = 32'hFFFF0000;
      tick();
    end
    check("wr dbg_ack", dbg_ack, 1);
    check("wr dbg_err", dbg_err, 0);
    check("wr dbg_rdata unchanged", dbg_rdata, 32'h33333333);
    check("wr cpu_ack", cpu_ack, 0);
    check("wr mem_valid drop", mem_valid, 0);
    dbg_req = 1'b0; dbg_we = 1'b0; mem_ready = 1'b0;
    tick();
    check("wr dbg_ack single", dbg_ack, 0);
    tick();
    check("wr idle mem_valid", mem_valid, 0);
    check("wr idle dbg_ack", dbg_ack, 0);

    // Timeout on the TIMEOUT=4 instance: prior good read, then memory never ready.
    cpu_addr = 32'h300; cpu_we = 1'b0; cpu_wdata = 32'h0000A5A5;
    do_reset();
    cpu_req = 1'b1;
    tick();
    mem_ready = 1'b1; mem_rdata = 32'hCAFEF00D;
    tick();
    check("to pre cpu_ack", t4_cpu_ack, 1);
    check("to pre cpu_rdata", t4_cpu_rdata, 32'hCAFEF00D);
    cpu_req = 1'b0; mem_ready = 1'b0;
    tick();
    cpu_req = 1'b1;
    tick();
    for (int i = 0; i < T_SHORT; i++) begin
      check("to mem_valid", t4_mem_valid, 1);
      check("to mem_addr", t4_mem_addr, 32'h300);
      check("to mem_we", t4_mem_we, 0);
      check("to mem_wdata", t4_mem_wdata, 32'h0000A5A5);
      check("to cpu_ack early", t4_cpu_ack, 0);
      tick();
    end
    check("to cpu_ack", t4_cpu_ack, 1);
    check("to cpu_err", t4_cpu_err, 1);
    check("to cpu_rdata", t4_cpu_rdata, 32'h0);
    check("to mem_valid drop", t4_mem_valid, 0);
    check("to dbg_ack", t4_dbg_ack, 0);
    cpu_req = 1'b0;
    tick();
    check("to idle mem_valid", t4_mem_valid, 0);
    check("to idle cpu_ack", t4_cpu_ack, 0);
    check("to dbg_err", t4_dbg_err, 0);
    check("to dbg_rdata", t4_dbg_rdata, 32'h0);

    // Reset in the second BUSY cycle after a tie moved the pointer.
    cpu_addr = 32'h100; dbg_addr = 32'h200; cpu_we = 1'b0; dbg_we = 1'b0;
    do_reset();
    cpu_req = 1'b1; dbg_req = 1'b1;
    tick();
    check("rst tie cpu first", mem_addr, 32'h100);
    tick();
    check("rst busy2 mem_valid", mem_valid, 1);
    reset = 1'b1;
    tick();
    check("rst mem_valid", mem_valid, 0);
    check("rst mem_addr", mem_addr, 0);
    check("rst mem_we", mem_we, 0);
    check("rst mem_wdata", mem_wdata, 0);
    check("rst cpu_ack", cpu_ack, 0);
    check("rst dbg_ack", dbg_ack, 0);
    check("rst cpu_rdata", cpu_rdata, 0);
    reset = 1'b0; cpu_req = 1'b0; dbg_req = 1'b1;
    tick();
    check("rst dbg grant valid", mem_valid, 1);
    check("rst dbg grant addr", mem_addr, 32'h200);
    check("rst no cpu ack", cpu_ack, 0);
    mem_ready = 1'b1; mem_rdata = 32'hABCD0123;
    tick();
    check("rst dbg_ack", dbg_ack, 1);
    check("rst dbg_rdata", dbg_rdata, 32'hABCD0123);
    check("rst cpu_ack after", cpu_ack, 0);
    dbg_req = 1'b0; mem_ready = 1'b0;
    tick();
    cpu_req = 1'b1; dbg_req = 1'b1;
    tick();
    check("rst pointer restored", mem_addr, 32'h100);
    mem_ready = 1'b1; mem_rdata = 32'h0F0F0F0F;
    tick();
    check("rst tie2 cpu_ack", cpu_ack, 1);
    check("rst tie2 cpu_rdata", cpu_rdata, 32'h0F0F0F0F);

    // Randomized traffic against a transaction-level reference.
    do_reset();
    for (int i = 0; i < 16; i++) mem_m[i] = $urandom;
    for (int p = 0; p < 2; p++) begin
      rq[p].active = 0; rq[p].we = 0; rq[p].addr = 0; rq[p].wdata = 0;
      rq[p].gap = $urandom_range(0, 3); rq[p].exp_rd = 0; rq[p].exp_err = 0;
    end
    phase = PH_IDLE; cur = 0; bidx = 0; wait_n = 0; last_tie = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      check("rnd cpu_ack", cpu_ack, (phase == PH_RESP && cur == 0));
      check("rnd dbg_ack", dbg_ack, (phase == PH_RESP && cur == 1));
      check("rnd mem_valid", mem_valid, (phase == PH_BUSY));
      if (phase == PH_BUSY) begin
        check("rnd mem_we", mem_we, rq[cur].we);
        check("rnd mem_addr", mem_addr, rq[cur].addr);
        check("rnd mem_wdata", mem_wdata, rq[cur].wdata);
      end
      check("rnd cpu_rdata", cpu_rdata, rq[0].exp_rd);
      check("rnd cpu_err", cpu_err, rq[0].exp_err);
      check("rnd dbg_rdata", dbg_rdata, rq[1].exp_rd);
      check("rnd dbg_err", dbg_err, rq[1].exp_err);

      nphase = phase;
      mem_ready = 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      if (phase == PH_BUSY) begin
        if (bidx == wait_n) begin
          mem_ready = 1'b1;
          if (!rq[cur].we) begin
            mem_rdata = mem_m[rq[cur].addr[5:2]];
            rq[cur].exp_rd = mem_rdata;
          end else begin
            mem_m[rq[cur].addr[5:2]] = rq[cur].wdata;
          end
          rq[cur].exp_err = 1'b0;
          nphase = PH_RESP;
        end else if (bidx == T_MAIN - 1) begin
          mem_ready = 1'b0;
          rq[cur].exp_rd = 32'h0;
          rq[cur].exp_err = 1'b1;
          nphase = PH_RESP;
        end else begin
          mem_ready = 1'b0;
          bidx++;
        end
      end else if (phase == PH_RESP) begin
        rq[cur].active = 1'b0;
        rq[cur].gap = $urandom_range(0, 3);
        nphase = PH_IDLE;
      end

      for (int p = 0; p < 2; p++) begin
        if (!rq[p].active) begin
          if (rq[p].gap == 0) begin
            rq[p].active = 1'b1;
            rq[p].we = 1'($urandom_range(0, 1));
            rq[p].addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            rq[p].wdata = $urandom;
          end else begin
            rq[p].gap--;
          end
        end
      end
      cpu_req = rq[0].active; cpu_we = rq[0].we; cpu_addr = rq[0].addr; cpu_wdata = rq[0].wdata;
      dbg_req = rq[1].active; dbg_we = rq[1].we; dbg_addr = rq[1].addr; dbg_wdata = rq[1].wdata;
      if (phase == PH_BUSY) begin
        if (cur == 0) begin
          cpu_we = 1'($urandom_range(0, 1)); cpu_addr = $urandom; cpu_wdata = $urandom;
        end else begin
          dbg_we = 1'($urandom_range(0, 1)); dbg_addr = $urandom; dbg_wdata = $urandom;
        end
      end

      if (phase == PH_IDLE) begin
        r0 = cpu_req;
        r1 = dbg_req;
        if (r0 || r1) begin
          if (r0 && r1) begin
            cur = (last_tie == 1) ? 0 : 1;
            last_tie = cur;
          end else begin
            cur = r1 ? 1 : 0;
          end
          bidx = 0;
          wait_n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, T_MAIN + 2)
                                                : $urandom_range(0, 3);
          nphase = PH_BUSY;
        end
      end
      phase = nphase;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
